fa_lru_array: RTL and testbench
===============================

FA_LRU_ARRAY -- requirements
Module: fa_lru_array

Interface
REQ-001 The module SHALL take parameter WAYS, default 8, number of fully-associative ways (power of two, >= 2).
REQ-002 The module SHALL take parameter LINE_W, default 128, line data width in bits.
REQ-003 The module SHALL take parameter TAG_W, default 12, tag width in bits; IDX_W = clog2(WAYS) is derived.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 lookup  in  1  probe request for tag this cycle.
REQ-007 wr  in  1  with lookup: on hit, overwrite line with wdata and set dirty.
REQ-008 fill  in  1  install tag/fill_data into a way.
REQ-009 tag  in  TAG_W  tag for lookup or fill.
REQ-010 wdata  in  LINE_W  write data for wr hit.
REQ-011 fill_data  in  LINE_W  line data for fill.
REQ-012 rvalid  out  1  registered; high one cycle after an accepted lookup.
REQ-013 hit  out  1  registered lookup result, qualified by rvalid.
REQ-014 hit_way  out  IDX_W  registered matching way, 0 on miss.
REQ-015 rdata  out  LINE_W  registered line data of hit way (post-write value if wr), 0 on miss.
REQ-016 victim_way  out  IDX_W  combinational replacement candidate.
REQ-017 victim_valid, victim_dirty  out  1 each  combinational state of victim_way.
REQ-018 victim_tag  out  TAG_W; victim_data  out  LINE_W  combinational contents of victim_way (for writeback before fill).

Function
REQ-019 Per way: valid bit, dirty bit, TAG_W tag, LINE_W data, IDX_W age; ages always form a permutation of 0..WAYS-1.
REQ-020 Hit SHALL mean exactly one valid way whose tag equals tag; duplicate tags SHALL never be created.
REQ-021 Lookup latency SHALL be 1 cycle: hit/hit_way/rdata/rvalid registered at the edge sampling lookup.
REQ-022 Touch of way w: age[w] <- 0; every way with age < old age[w] increments by 1; others unchanged.
REQ-023 Lookup hit SHALL touch hit way; lookup miss SHALL change no state.
REQ-024 lookup&&wr on hit: data <- wdata, dirty <- 1, touch; lookup&&wr on miss: no state change.
REQ-025 Victim selection: lowest-index invalid way if any; else way with age WAYS-1.
REQ-026 fill with tag not resident: victim_way gets valid=1, dirty=0, tag, fill_data; touch it.
REQ-027 fill with tag already resident: that way's data <- fill_data, dirty <- 0, touch it; victim untouched.
REQ-028 fill and lookup same cycle: fill SHALL win; lookup dropped, rvalid=0 next cycle.
REQ-029 Outputs without rvalid: hit=0, hit_way=0, rdata=0.
REQ-030 Victim outputs SHALL reflect state after the most recent edge (combinational from registers, not from inputs).

Reset
REQ-031 reset_n=0 at an edge: all valid=0, dirty=0, tags=0, data=0, age[i]=WAYS-1-i, rvalid=0, hit=0, hit_way=0, rdata=0.
REQ-032 Reset SHALL override lookup/wr/fill in the same cycle; operation in flight (rvalid pending) SHALL be cancelled.
REQ-033 After reset with WAYS=8: victim_way=0, victim_valid=0, victim_dirty=0.

Verification
REQ-034 Reset then 8 fills of tags 0x10..0x17 -> ways 0..7 filled in order; 9th fill tag 0x20 -> lands in way 0 (oldest), victim before fill reports tag 0x10.
REQ-035 After REQ-034 fills, lookup 0x11 -> next cycle rvalid=1, hit=1, hit_way=1; subsequent victim_way=2.
REQ-036 lookup+wr tag 0x12, wdata=0xFFFF -> rdata=0xFFFF, hit_way=2; victim at way 2 later reports victim_dirty=1.
REQ-037 Lookup 0x55 (absent) -> rvalid=1, hit=0, rdata=0, ages unchanged; fill 0x13 while resident -> overwrites way 3, dirty=0, no eviction.
REQ-038 fill and lookup same cycle -> fill applied, rvalid=0; reset_n=0 mid-sequence -> all ways invalid, victim_way=0 next cycle.

Source files
------------

// File: rtl/fa_lru_array.sv
// fa_lru_array: fully-associative line array with true-LRU ages, 1-cycle lookup and fill/victim support.
module fa_lru_array #(
  parameter  int WAYS   = 8,
  parameter  int LINE_W = 128,
  parameter  int TAG_W  = 12,
  localparam int IDX_W  = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              lookup_i,
  input  logic              wr_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic [LINE_W-1:0] fill_data_i,
  output logic              rvalid_o,
  output logic              hit_o,
  output logic [IDX_W-1:0]  hit_way_o,
  output logic [LINE_W-1:0] rdata_o,
  output logic [IDX_W-1:0]  victim_way_o,
  output logic              victim_valid_o,
  output logic              victim_dirty_o,
  output logic [TAG_W-1:0]  victim_tag_o,
  output logic [LINE_W-1:0] victim_data_o
);
  logic [WAYS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [WAYS];
  logic [TAG_W-1:0]  tag_d  [WAYS];
  logic [LINE_W-1:0] data_q [WAYS];
  logic [LINE_W-1:0] data_d [WAYS];
  logic [IDX_W-1:0]  age_q  [WAYS];
  logic [IDX_W-1:0]  age_d  [WAYS];
  logic              rvalid_q, rvalid_d, hit_q, hit_d;
  logic [IDX_W-1:0]  hit_way_q, hit_way_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              hit_any, touch;
  logic [IDX_W-1:0]  hit_idx, victim_idx, tw;
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (valid_q[i] && tag_q[i] == tag_i) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
  end
  // Oldest way by default; any invalid way overrides, lowest index last so it wins.
  always_comb begin
    victim_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (age_q[i] == IDX_W'(WAYS - 1)) victim_idx = IDX_W'(i);
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid_q[i]) victim_idx = IDX_W'(i);
  end
  always_comb begin
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    tag_d     = tag_q;
    data_d    = data_q;
    age_d     = age_q;
    touch     = 1'b0;
    tw        = '0;
    rvalid_d  = 1'b0;
    hit_d     = 1'b0;
    hit_way_d = '0;
    rdata_d   = '0;
    if (fill_i) begin
      tw          = hit_any ? hit_idx : victim_idx;
      touch       = 1'b1;
      valid_d[tw] = 1'b1;
      dirty_d[tw] = 1'b0;
      tag_d[tw]   = tag_i;
      data_d[tw]  = fill_data_i;
    end else if (lookup_i) begin
      rvalid_d = 1'b1;
      if (hit_any) begin
        tw        = hit_idx;
        touch     = 1'b1;
        hit_d     = 1'b1;
        hit_way_d = hit_idx;
        rdata_d   = wr_i ? wdata_i : data_q[hit_idx];
        if (wr_i) begin
          data_d[hit_idx]  = wdata_i;
          dirty_d[hit_idx] = 1'b1;
        end
      end
    end
    // Touch keeps ages a permutation: the touched way becomes 0, younger ways shift up by one.
    if (touch)
      for (int i = 0; i < WAYS; i++)
        age_d[i] = (IDX_W'(i) == tw) ? '0 :
                   (age_q[i] < age_q[tw]) ? age_q[i] + IDX_W'(1) : age_q[i];
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      rvalid_q  <= 1'b0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      rdata_q   <= '0;
      for (int i = 0; i < WAYS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        age_q[i]  <= IDX_W'(WAYS - 1 - i);
      end
    end else begin
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      age_q     <= age_d;
      rvalid_q  <= rvalid_d;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
      rdata_q   <= rdata_d;
    end
  end
  assign rvalid_o       = rvalid_q;
  assign hit_o          = hit_q;
  assign hit_way_o      = hit_way_q;
  assign rdata_o        = rdata_q;
  assign victim_way_o   = victim_idx;
  assign victim_valid_o = valid_q[victim_idx];
  assign victim_dirty_o = dirty_q[victim_idx];
  assign victim_tag_o   = tag_q[victim_idx];
  assign victim_data_o  = data_q[victim_idx];
endmodule

// File: tb/tb_fa_lru_array.sv
// tb_fa_lru_array: directed scenarios for fa_lru_array with hand-computed expectations.
module tb_fa_lru_array;
  logic         clk = 1'b0, reset_n = 1'b0, lookup = 1'b0, wr = 1'b0, fill = 1'b0;
  logic [11:0]  tag = '0;
  logic [127:0] wdata = '0, fill_data = '0;
  logic         rvalid, hit, victim_valid, victim_dirty;
  logic [2:0]   hit_way, victim_way;
  logic [127:0] rdata, victim_data;
  logic [11:0]  victim_tag;
  int checks = 0, errors = 0;

  fa_lru_array dut (
    .clk_i(clk), .reset_n_i(reset_n), .lookup_i(lookup), .wr_i(wr), .fill_i(fill),
    .tag_i(tag), .wdata_i(wdata), .fill_data_i(fill_data),
    .rvalid_o(rvalid), .hit_o(hit), .hit_way_o(hit_way), .rdata_o(rdata),
    .victim_way_o(victim_way), .victim_valid_o(victim_valid), .victim_dirty_o(victim_dirty),
    .victim_tag_o(victim_tag), .victim_data_o(victim_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    lookup = 1'b0; wr = 1'b0; fill = 1'b0;
  endtask

  task automatic do_lookup(input logic [11:0] t, input logic w, input logic [127:0] d);
    lookup = 1'b1; wr = w; tag = t; wdata = d;
    step();
  endtask

  task automatic do_fill(input logic [11:0] t, input logic [127:0] d);
    fill = 1'b1; tag = t; fill_data = d;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0h exp 0", rvalid); end
    checks++; if (hit !== 1'b0 || hit_way !== 3'd0 || rdata !== 128'h0) begin errors++; $display("FAIL reset_outs hit %0h way %0h rdata %0h exp 0", hit, hit_way, rdata); end
    checks++; if (victim_way !== 3'd0 || victim_valid !== 1'b0 || victim_dirty !== 1'b0) begin errors++; $display("FAIL reset_victim way %0h v %0h d %0h exp 0 0 0", victim_way, victim_valid, victim_dirty); end
    checks++; if (victim_tag !== 12'h0 || victim_data !== 128'h0) begin errors++; $display("FAIL reset_victim_contents tag %0h data %0h exp 0", victim_tag, victim_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      checks++; if (victim_way !== 3'(i)) begin errors++; $display("FAIL fill_victim_%0d got %0h exp %0h", i, victim_way, i); end
      do_fill(12'h10 + 12'(i), 128'h100 + 128'(i));
    end
    checks++; if (victim_way !== 3'd0 || victim_tag !== 12'h10 || victim_valid !== 1'b1 || victim_data !== 128'h100) begin errors++; $display("FAIL full_victim way %0h tag %0h v %0h data %0h exp 0 10 1 100", victim_way, victim_tag, victim_valid, victim_data); end
    do_fill(12'h20, 128'hAA);
    checks++; if (victim_way !== 3'd1 || victim_tag !== 12'h11) begin errors++; $display("FAIL evict_victim way %0h tag %0h exp 1 11", victim_way, victim_tag); end
    do_lookup(12'h20, 1'b0, '0);
    checks++; if (rvalid !== 1'b1 || hit !== 1'b1 || hit_way !== 3'd0 || rdata !== 128'hAA) begin errors++; $display("FAIL lookup_20 rv %0h hit %0h way %0h rdata %0h exp 1 1 0 aa", rvalid, hit, hit_way, rdata); end
    do_lookup(12'h10, 1'b0, '0);
    checks++; if (rvalid !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL lookup_evicted rv %0h hit %0h exp 1 0", rvalid, hit); end
  endtask

  task automatic test_lookup();
    do_lookup(12'h11, 1'b0, '0);
    checks++; if (rvalid !== 1'b1 || hit !== 1'b1 || hit_way !== 3'd1 || rdata !== 128'h101) begin errors++; $display("FAIL lookup_11 rv %0h hit %0h way %0h rdata %0h exp 1 1 1 101", rvalid, hit, hit_way, rdata); end
    checks++; if (victim_way !== 3'd2) begin errors++; $display("FAIL victim_after_11 got %0h exp 2", victim_way); end
    do_lookup(12'h12, 1'b1, 128'hFFFF);
    checks++; if (hit !== 1'b1 || hit_way !== 3'd2 || rdata !== 128'hFFFF) begin errors++; $display("FAIL write_12 hit %0h way %0h rdata %0h exp 1 2 ffff", hit, hit_way, rdata); end
    checks++; if (victim_way !== 3'd3) begin errors++; $display("FAIL victim_after_wr got %0h exp 3", victim_way); end
    do_lookup(12'h55, 1'b0, '0);
    checks++; if (rvalid !== 1'b1 || hit !== 1'b0 || hit_way !== 3'd0 || rdata !== 128'h0) begin errors++; $display("FAIL miss_55 rv %0h hit %0h way %0h rdata %0h exp 1 0 0 0", rvalid, hit, hit_way, rdata); end
    checks++; if (victim_way !== 3'd3) begin errors++; $display("FAIL miss_ages got %0h exp 3", victim_way); end
    do_lookup(12'h77, 1'b1, 128'h1234);
    checks++; if (rvalid !== 1'b1 || hit !== 1'b0 || victim_way !== 3'd3 || victim_dirty !== 1'b0) begin errors++; $display("FAIL wr_miss rv %0h hit %0h vway %0h vd %0h exp 1 0 3 0", rvalid, hit, victim_way, victim_dirty); end
    step();
    checks++; if (rvalid !== 1'b0 || hit !== 1'b0 || rdata !== 128'h0) begin errors++; $display("FAIL idle_outs rv %0h hit %0h rdata %0h exp 0 0 0", rvalid, hit, rdata); end
  endtask

  task automatic test_refill();
    do_fill(12'h13, 128'h333);
    checks++; if (victim_way !== 3'd4 || victim_tag !== 12'h14) begin errors++; $display("FAIL refill_victim way %0h tag %0h exp 4 14", victim_way, victim_tag); end
    do_lookup(12'h13, 1'b0, '0);
    checks++; if (hit !== 1'b1 || hit_way !== 3'd3 || rdata !== 128'h333) begin errors++; $display("FAIL refill_lookup hit %0h way %0h rdata %0h exp 1 3 333", hit, hit_way, rdata); end
    do_lookup(12'h14, 1'b0, '0);
    do_lookup(12'h15, 1'b0, '0);
    do_lookup(12'h16, 1'b0, '0);
    do_lookup(12'h17, 1'b0, '0);
    do_lookup(12'h20, 1'b0, '0);
    do_lookup(12'h11, 1'b0, '0);
    checks++; if (victim_way !== 3'd2 || victim_dirty !== 1'b1 || victim_tag !== 12'h12 || victim_data !== 128'hFFFF) begin errors++; $display("FAIL dirty_victim way %0h d %0h tag %0h data %0h exp 2 1 12 ffff", victim_way, victim_dirty, victim_tag, victim_data); end
  endtask

  task automatic test_fill_lookup_same();
    fill = 1'b1; lookup = 1'b1; tag = 12'h30; fill_data = 128'h3030;
    step();
    checks++; if (rvalid !== 1'b0 || hit !== 1'b0) begin errors++; $display("FAIL fill_wins rv %0h hit %0h exp 0 0", rvalid, hit); end
    checks++; if (victim_way !== 3'd3 || victim_dirty !== 1'b0) begin errors++; $display("FAIL fill_wins_victim way %0h d %0h exp 3 0", victim_way, victim_dirty); end
    do_lookup(12'h30, 1'b0, '0);
    checks++; if (hit !== 1'b1 || hit_way !== 3'd2 || rdata !== 128'h3030) begin errors++; $display("FAIL fill_wins_lookup hit %0h way %0h rdata %0h exp 1 2 3030", hit, hit_way, rdata); end
  endtask

  task automatic test_back_to_back();
    lookup = 1'b1; tag = 12'h14;
    @(posedge clk); #1;
    tag = 12'h15;
    checks++; if (rvalid !== 1'b1 || hit_way !== 3'd4 || rdata !== 128'h104) begin errors++; $display("FAIL b2b_0 rv %0h way %0h rdata %0h exp 1 4 104", rvalid, hit_way, rdata); end
    @(posedge clk); #1;
    lookup = 1'b0;
    checks++; if (rvalid !== 1'b1 || hit_way !== 3'd5 || rdata !== 128'h105) begin errors++; $display("FAIL b2b_1 rv %0h way %0h rdata %0h exp 1 5 105", rvalid, hit_way, rdata); end
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end rv %0h exp 0", rvalid); end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0; lookup = 1'b1; fill = 1'b1; tag = 12'h11; fill_data = 128'h9;
    step();
    reset_n = 1'b1;
    checks++; if (rvalid !== 1'b0 || hit !== 1'b0 || rdata !== 128'h0) begin errors++; $display("FAIL mid_reset_outs rv %0h hit %0h rdata %0h exp 0 0 0", rvalid, hit, rdata); end
    checks++; if (victim_way !== 3'd0 || victim_valid !== 1'b0 || victim_tag !== 12'h0) begin errors++; $display("FAIL mid_reset_victim way %0h v %0h tag %0h exp 0 0 0", victim_way, victim_valid, victim_tag); end
    do_lookup(12'h11, 1'b0, '0);
    checks++; if (rvalid !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL post_reset_miss rv %0h hit %0h exp 1 0", rvalid, hit); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lookup();
    test_refill();
    test_fill_lookup_same();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
